// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered result and NZCV flags.
//
// One operation is accepted per start/ready handshake. Single-cycle ops
// complete with a one-cycle `done` pulse two cycles after acceptance. When
// the ALU_SEQ_MUL_EN macro is defined, op 8 is an iterative shift-add
// multiply that completes WIDTH+2 cycles after acceptance; otherwise op 8
// is reported as illegal like ops 9..15.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op, set_flags, a, b
//                       request and operands, sampled when ready=1
//   ready               idle, can accept start
//   done                one-cycle completion pulse
//   illegal_op          pulses with done for unsupported ops
//   result              registered result (held across flag-only/illegal ops)
//   flag_n/z/c/v        registered flags
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             illegal_op,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_RSB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_TST = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC} state_t;
`endif

    state_t           state;
    logic [3:0]       op_q;
    logic             sf_q;
    logic [WIDTH-1:0] a_q, b_q;

    // Single-cycle datapath, evaluated on the captured operands.
    logic [WIDTH:0]   sum, d_ab, d_ba;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, wr_res, wr_flg, legal;

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        d_ab    = {1'b0, a_q} - {1'b0, b_q};
        d_ba    = {1'b0, b_q} - {1'b0, a_q};
        alu_res = '0;
        alu_c   = flag_c;
        alu_v   = flag_v;
        wr_res  = 1'b1;
        wr_flg  = sf_q;
        legal   = 1'b1;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = d_ab[WIDTH-1:0];
                alu_c   = ~d_ab[WIDTH];   // bit WIDTH is the borrow
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_ab[WIDTH-1] != a_q[WIDTH-1]);
                if (op_q == OP_CMP) begin
                    wr_res = 1'b0;
                    wr_flg = 1'b1;
                end
            end
            OP_RSB: begin
                alu_res = d_ba[WIDTH-1:0];
                alu_c   = ~d_ba[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_ba[WIDTH-1] != b_q[WIDTH-1]);
            end
            OP_AND, OP_TST: begin
                alu_res = a_q & b_q;
                if (op_q == OP_TST) begin
                    wr_res = 1'b0;
                    wr_flg = 1'b1;
                end
            end
            OP_NOT: alu_res = ~b_q;
            OP_MOV: alu_res = b_q;
            default: begin
                legal  = 1'b0;
                wr_res = 1'b0;
                wr_flg = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ready      <= 1'b1;
            done       <= 1'b0;
            illegal_op <= 1'b0;
            result     <= '0;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
            op_q       <= '0;
            sf_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
`ifdef ALU_SEQ_MUL_EN
            acc        <= '0;
            cnt        <= '0;
`endif
        end else begin
            done       <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        sf_q  <= set_flags;
                        a_q   <= a;
                        b_q   <= b;
                        ready <= 1'b0;
                        state <= S_EXEC;
`ifdef ALU_SEQ_MUL_EN
                        acc   <= '0;
                        cnt   <= '0;
                        if (op == OP_MUL) state <= S_MUL;
`endif
                    end
                end
                S_EXEC: begin
                    state      <= S_IDLE;
                    ready      <= 1'b1;
                    done       <= 1'b1;
                    illegal_op <= ~legal;
                    if (wr_res) result <= alu_res;
                    if (wr_flg) begin
                        flag_n <= alu_res[WIDTH-1];
                        flag_z <= (alu_res == '0);
                        flag_c <= alu_c;
                        flag_v <= alu_v;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                S_MUL: begin
                    // WIDTH shift-add steps, then one cycle to register the product.
                    if (cnt != CW'(WIDTH)) begin
                        if (b_q[0]) acc <= acc + a_q;
                        a_q <= a_q << 1;
                        b_q <= b_q >> 1;
                        cnt <= cnt + 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        ready  <= 1'b1;
                        done   <= 1'b1;
                        result <= acc;
                        if (sf_q) begin
                            flag_n <= acc[WIDTH-1];
                            flag_z <= (acc == '0);
                        end
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
